// File: rtl/logical_tile_io_multi_cfg.sv
// Multi-channel IO logical tile: one ccff chain segment with a commit shadow register,
// per-channel output enable, optional input synchroniser and shift-completion flag.
module logical_tile_io_multi_cfg #(
    parameter int unsigned NUM_IO      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              ccff_head,
    input  logic              ccff_en,
    input  logic              cfg_commit,
    input  logic              isol_n,
    input  logic [NUM_IO-1:0] io_outpad,
    input  logic [NUM_IO-1:0] io_oe,
    input  logic [NUM_IO-1:0] gfpga_pad_io_soc_in,
    output logic              ccff_tail,
    output logic              cfg_complete,
    output logic [NUM_IO-1:0] gfpga_pad_io_soc_dir,
    output logic [NUM_IO-1:0] gfpga_pad_io_soc_out,
    output logic [NUM_IO-1:0] io_inpad
);

    localparam int unsigned CHAIN_LEN = 3 * NUM_IO;
    localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1);

    logic [CHAIN_LEN-1:0]               chain_q, chain_d;
    logic [CHAIN_LEN-1:0]               act_q, act_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic                               complete_q;
    logic [SYNC_STAGES-1:0][NUM_IO-1:0] sync_q;

    // Commit captures the pre-shift chain; the shift proceeds in the same cycle.
    always_comb begin
        chain_d = chain_q;
        act_d   = act_q;
        cnt_d   = cnt_q;
        if (cfg_commit) begin
            act_d = chain_q;
        end
        if (ccff_en) begin
            chain_d = {chain_q[CHAIN_LEN-2:0], ccff_head};
        end
        if (cfg_commit) begin
            cnt_d = ccff_en ? CNT_W'(1) : '0;
        end else if (ccff_en && (cnt_q != CNT_W'(CHAIN_LEN))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge prog_clk) begin
        if (!prog_reset) begin
            chain_q    <= '0;
            act_q      <= '0;
            cnt_q      <= '0;
            complete_q <= 1'b0;
            sync_q     <= '0;
        end else begin
            chain_q    <= chain_d;
            act_q      <= act_d;
            cnt_q      <= cnt_d;
            complete_q <= (cnt_d == CNT_W'(CHAIN_LEN));
            // Synchroniser always runs so a REG change needs no flush.
            sync_q[0]  <= gfpga_pad_io_soc_in;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign ccff_tail    = chain_q[CHAIN_LEN-1];
    assign cfg_complete = complete_q;

    // Pad-side gating from the active config; isolation overrides everything.
    always_comb begin
        gfpga_pad_io_soc_dir = '0;
        gfpga_pad_io_soc_out = '0;
        io_inpad             = '0;
        for (int k = 0; k < int'(NUM_IO); k++) begin
            gfpga_pad_io_soc_dir[k] = isol_n & act_q[3*k]
                                      & (act_q[3*k+1] ? io_oe[k] : 1'b1);
            gfpga_pad_io_soc_out[k] = isol_n & io_outpad[k];
            io_inpad[k]             = isol_n & (act_q[3*k+2] ? sync_q[SYNC_STAGES-1][k]
                                                             : gfpga_pad_io_soc_in[k]);
        end
    end

endmodule

// File: doc/logical_tile_io_multi_cfg.md
Name: logical_tile_io_multi_cfg

Overview:
- Parametrised, multi-channel successor of the single-pad IO logical tile.
- Packs NUM_IO pad channels behind one configuration-chain segment, with a shadow (commit) register for glitch-free reconfiguration.
- Adds per-channel dynamic output enable, an optional input synchroniser, and shift-completion tracking.
- Sits at the fabric periphery between grid IO pins and the gfpga_pad_io_soc_* SoC pad signals; it is one link of the global ccff chain.

Parameters:
- NUM_IO, 4: number of pad channels, 1..32.
- SYNC_STAGES, 2: input synchroniser depth for registered-input channels, 1..3.
- CHAIN_LEN, derived = 3*NUM_IO: configuration bits in this segment.

Ports:
- prog_clk  in  1  single clock for all state.
- prog_reset  in  1  active-low reset, synchronous to prog_clk.
- ccff_head  in  1  configuration chain serial input.
- ccff_en  in  1  chain shift enable.
- cfg_commit  in  1  one-cycle pulse; copies chain contents into the active configuration.
- isol_n  in  1  active-low isolation.
- io_outpad  in  NUM_IO  fabric-to-pad data.
- io_oe  in  NUM_IO  fabric dynamic output enable.
- gfpga_pad_io_soc_in  in  NUM_IO  pad-to-fabric data.
- ccff_tail  out  1  chain serial output.
- cfg_complete  out  1  CHAIN_LEN shifts have occurred since the last commit or reset.
- gfpga_pad_io_soc_dir  out  NUM_IO  1 = pad driven by the fabric.
- gfpga_pad_io_soc_out  out  NUM_IO  data to the pad.
- io_inpad  out  NUM_IO  data to the fabric.

Behaviour:
- Clocking and reset
  - Exactly one clock, prog_clk.
  - prog_reset is synchronous and active-low: sampled low on a prog_clk edge, it clears chain, active config, shift counter and synchroniser flops to 0.
  - Reset takes priority over ccff_en and cfg_commit in the same cycle.
  - Reset values: ccff_tail=0, cfg_complete=0, all soc_dir=0, soc_out=0, io_inpad=0. The all-zero config means input mode, unregistered.
- Chain
  - When ccff_en=1: chain[0]<=ccff_head and chain[i]<=chain[i-1].
  - ccff_tail = chain[CHAIN_LEN-1] (registered); the head-to-tail latency is CHAIN_LEN cycles.
  - When ccff_en=0 the chain holds.
- Channel k configuration bits, in the active config
  - [3k] = OUT (1 = output-capable).
  - [3k+1] = DYN (1 = dir follows io_oe[k]).
  - [3k+2] = REG (1 = synchronised input).
- Commit
  - cfg_commit=1: active <= chain contents as they stand at the start of the cycle (pre-shift value).
  - Active config is unchanged otherwise.
  - The shift, if any, proceeds in the same cycle.
- Shift counter
  - Width clog2(CHAIN_LEN+1).
  - Increments on each ccff_en cycle and saturates at CHAIN_LEN.
  - cfg_commit sets it to 0, or to 1 if ccff_en is also high that cycle.
  - cfg_complete = (count==CHAIN_LEN), registered.
- Output path, combinational from the active config
  - soc_dir[k] = isol_n & OUT & (DYN ? io_oe[k] : 1).
  - soc_out[k] = isol_n & io_outpad[k].
- Input path
  - REG=0: io_inpad[k] = isol_n & soc_in[k], zero latency.
  - REG=1: io_inpad[k] = isol_n & sync[k][SYNC_STAGES-1].
  - The synchroniser shifts every cycle regardless of config; latency is SYNC_STAGES cycles.
  - Changing REG via commit takes effect on the cycle after commit. No flush is required; the flops are always running.
- Isolation
  - isol_n=0 forces soc_dir, soc_out and io_inpad to 0 combinationally.
  - Chain, active config and synchronisers are unaffected.
- Mid-shift reset
  - The chain clears; the active config also clears, so pads return to input mode.
  - cfg_complete=0.

Test Plan:
1. Reset: hold prog_reset=0 for 2 edges with ccff_en=1 and ccff_head=1 -> ccff_tail=0, cfg_complete=0, soc_dir=4'b0000, io_inpad=0.
2. NUM_IO=4: shift 12 bits so that ch0 is OUT=1 and ch2 is OUT=1,DYN=1, then pulse cfg_commit -> cfg_complete=1 after the 12th shift; after commit soc_dir=4'b0001 with io_oe=0, and soc_dir=4'b0101 with io_oe[2]=1.
3. Shift 11 bits only -> cfg_complete stays 0. A commit still applies the partial contents: active equals chain, and the counter reads 0.
4. cfg_commit and ccff_en in the same cycle -> active takes the pre-shift chain value, the counter equals 1, and ccff_tail advances by one bit.
5. Ch1 REG=1, SYNC_STAGES=2: toggle soc_in[1] 0->1 -> io_inpad[1] rises exactly 2 edges later. Ch3 REG=0 -> same cycle.
6. Configured outputs with io_outpad=4'hF, then drop isol_n=0 -> soc_out=0, soc_dir=0, io_inpad=0 immediately; raise isol_n -> the previous values return without reconfiguration.
